// File: rtl/alu_spi_ctrl_if.sv
// SPI pins and ALU operand/result bus shared between the controller and its environment.
// alu_load is a one-clk strobe: operands are stable from that cycle on, and the ALU must
// present a settled result/flags SETTLE_CYCLES clocks later; there is no back-pressure.
interface alu_spi_ctrl_if;
  logic       CS;
  logic       SLCK;
  logic       MOSI;
  logic       MISO;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic       alu_load;
  logic [3:0] alu_result;
  logic       N;
  logic       Z;
  logic       C;
  logic       V;

  modport slave (
    input  CS, SLCK, MOSI, alu_result, N, Z, C, V,
    output MISO, alu_a, alu_b, alu_op, alu_load
  );

  modport master (
    output CS, SLCK, MOSI, alu_result, N, Z, C, V,
    input  MISO, alu_a, alu_b, alu_op, alu_load
  );
endinterface

// File: rtl/alu_spi_ctrl.sv
// SPI (mode 0) slave that receives a 10-bit {op,A,B} frame, drives an external ALU,
// and shifts back the 8-bit {result,N,Z,C,V} frame within the same CS window.
module alu_spi_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_spi_ctrl_if.slave    bus,
  output logic [3:0]       res_q,
  output logic [3:0]       flags_q,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RX   = 3'd1,
    EXEC = 3'd2,
    TX   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_slck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_slck_prev;

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_bit_cnt;
  logic [SW-1:0] r_settle_cnt;
  logic [9:0]    r_rx_sh;
  logic [7:0]    r_tx_sh;
  logic          r_miso;
  logic [3:0]    r_alu_a;
  logic [3:0]    r_alu_b;
  logic [1:0]    r_alu_op;
  logic          r_alu_load;
  logic [3:0]    r_res;
  logic [3:0]    r_flags;
  logic          r_done;
  logic          r_err;

  logic w_cs;
  logic w_slck;
  logic w_mosi;
  logic w_slck_rise;
  logic w_slck_fall;
  logic w_shift_in;
  logic w_clr_cnt;
  logic w_inc_cnt;
  logic w_settle_inc;
  logic w_load;
  logic w_capture;
  logic w_tx_shift;
  logic w_done;
  logic w_err;

  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_slck      = r_slck_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_slck_rise = w_slck & ~r_slck_prev;
  assign w_slck_fall = ~w_slck & r_slck_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_sync   <= '1;
      r_slck_sync <= '0;
      r_mosi_sync <= '0;
      r_slck_prev <= 1'b0;
    end else begin
      r_cs_sync[0]   <= bus.CS;
      r_slck_sync[0] <= bus.SLCK;
      r_mosi_sync[0] <= bus.MOSI;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_cs_sync[i]   <= r_cs_sync[i-1];
        r_slck_sync[i] <= r_slck_sync[i-1];
        r_mosi_sync[i] <= r_mosi_sync[i-1];
      end
      r_slck_prev <= w_slck;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_in   = 1'b0;
    w_clr_cnt    = 1'b0;
    w_inc_cnt    = 1'b0;
    w_settle_inc = 1'b0;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    w_tx_shift   = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        // A rise coinciding with the CS-low detection is kept as the first bit.
        if (!w_cs) begin
          w_state_next = RX;
          if (w_slck_rise) begin
            w_shift_in = 1'b1;
            w_inc_cnt  = 1'b1;
          end else begin
            w_clr_cnt = 1'b1;
          end
        end
      end
      RX: begin
        if (w_cs) begin
          w_state_next = IDLE;
          w_err        = 1'b1;
          w_clr_cnt    = 1'b1;
        end else if (w_slck_rise) begin
          w_shift_in = 1'b1;
          if (r_bit_cnt == 4'd9) begin
            w_state_next = EXEC;
            w_clr_cnt    = 1'b1;
          end else begin
            w_inc_cnt = 1'b1;
          end
        end
      end
      EXEC: begin
        if (w_cs) begin
          w_state_next = IDLE;
          w_err        = 1'b1;
        end else if (r_settle_cnt == '0) begin
          w_load       = 1'b1;
          w_settle_inc = 1'b1;
        end else if (r_settle_cnt == SW'(SETTLE_CYCLES)) begin
          w_capture    = 1'b1;
          w_state_next = TX;
          w_clr_cnt    = 1'b1;
        end else begin
          w_settle_inc = 1'b1;
        end
      end
      TX: begin
        if (w_cs) begin
          w_state_next = IDLE;
          w_err        = 1'b1;
          w_clr_cnt    = 1'b1;
        end else if (w_slck_rise) begin
          if (r_bit_cnt == 4'd7) begin
            w_state_next = DONE;
            w_done       = 1'b1;
            w_clr_cnt    = 1'b1;
          end else begin
            w_inc_cnt = 1'b1;
          end
        end else if (w_slck_fall && r_bit_cnt != 4'd0) begin
          // A fall before the first TX rise is the trailing edge of the last RX bit.
          w_tx_shift = 1'b1;
        end
      end
      DONE: begin
        if (w_cs) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 4'd0;
      r_settle_cnt <= '0;
      r_rx_sh      <= 10'd0;
      r_tx_sh      <= 8'd0;
      r_miso       <= 1'b0;
      r_alu_a      <= 4'b0001;
      r_alu_b      <= 4'b0011;
      r_alu_op     <= 2'b00;
      r_alu_load   <= 1'b0;
      r_res        <= 4'd0;
      r_flags      <= 4'd0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_alu_load <= w_load;
      r_done     <= w_done;
      r_err      <= w_err;

      if (w_clr_cnt)      r_bit_cnt <= 4'd0;
      else if (w_inc_cnt) r_bit_cnt <= r_bit_cnt + 4'd1;

      if (w_settle_inc) r_settle_cnt <= r_settle_cnt + SW'(1);
      else              r_settle_cnt <= '0;

      if (w_shift_in) r_rx_sh <= {r_rx_sh[8:0], w_mosi};

      if (w_load) begin
        r_alu_op <= r_rx_sh[9:8];
        r_alu_a  <= r_rx_sh[7:4];
        r_alu_b  <= r_rx_sh[3:0];
      end

      if (w_capture) begin
        r_tx_sh <= {bus.alu_result, bus.N, bus.Z, bus.C, bus.V};
        r_res   <= bus.alu_result;
        r_flags <= {bus.N, bus.Z, bus.C, bus.V};
        r_miso  <= bus.alu_result[3];
      end else if (w_tx_shift) begin
        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
        r_miso  <= r_tx_sh[6];
      end else if (w_state_next == IDLE) begin
        r_miso <= 1'b0;
      end
    end
  end

  assign bus.MISO     = r_miso & ~w_cs & (r_state == TX || r_state == DONE);
  assign bus.alu_a    = r_alu_a;
  assign bus.alu_b    = r_alu_b;
  assign bus.alu_op   = r_alu_op;
  assign bus.alu_load = r_alu_load;

  assign res_q      = r_res;
  assign flags_q    = r_flags;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_done;
  assign frame_err  = r_err;
  assign o_state    = r_state;

endmodule

// File: tb/tb_alu_spi_ctrl.sv
// Directed bench for alu_spi_ctrl: an SPI master task, a 4-bit ALU model on the
// operand bus, pulse counters, and immediate-assertion checks against hand-computed values.
module tb_alu_spi_ctrl;

  localparam int HALF = 6;

  logic       clk;
  logic       rst;
  logic [3:0] res_q;
  logic [3:0] flags_q;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic [2:0] o_state;

  alu_spi_ctrl_if bus ();

  alu_spi_ctrl #(.SYNC_STAGES(2), .SETTLE_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .res_q      (res_q),
    .flags_q    (flags_q),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .o_state    (o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: op 00 = A+B; other ops fall back to A&B with C=V=0
  logic [4:0] w_sum;
  always_comb begin
    w_sum          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    bus.alu_result = bus.alu_a & bus.alu_b;
    bus.C          = 1'b0;
    bus.V          = 1'b0;
    if (bus.alu_op == 2'b00) begin
      bus.alu_result = w_sum[3:0];
      bus.C          = w_sum[4];
      bus.V          = (bus.alu_a[3] == bus.alu_b[3]) && (w_sum[3] != bus.alu_a[3]);
    end
    bus.N = bus.alu_result[3];
    bus.Z = (bus.alu_result == 4'd0);
  end

  // pulse counters (count clk cycles high)
  int n_load, n_done, n_err, n_both;
  initial begin
    n_load = 0; n_done = 0; n_err = 0; n_both = 0;
  end
  always @(negedge clk) begin
    if (bus.alu_load) n_load++;
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (frame_done && frame_err) n_both++;
  end

  // scoreboard
  int         n_checks;
  int         n_fail;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dout(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed %0h expected <empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'd0, obs}, {24'd0, e});
    end
  endtask

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_frame(input logic [9:0] din, input int abort_bits, input int rst_bit,
                           output logic [7:0] dout);
    dout   = 8'd0;
    bus.CS = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 10; i++) begin
      if (abort_bits == i) begin
        bus.CS = 1'b1;
        wait_clk(HALF);
        return;
      end
      bus.MOSI = din[9-i];
      wait_clk(HALF);
      bus.SLCK = 1'b1;
      wait_clk(HALF);
      bus.SLCK = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      wait_clk(HALF);
      if (rst_bit == i) begin
        rst = 1'b1;
        wait_clk(2);
        bus.CS   = 1'b1;
        bus.SLCK = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(HALF);
        return;
      end
      dout[7-i] = bus.MISO;
      bus.SLCK  = 1'b1;
      wait_clk(HALF);
      bus.SLCK  = 1'b0;
    end
    wait_clk(HALF);
    bus.CS = 1'b1;
  endtask

  logic [7:0] dout_a;
  logic [7:0] dout_b;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.CS   = 1'b1;
    bus.SLCK = 1'b0;
    bus.MOSI = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);

    // reset state
    check("rst_alu_a",   bus.alu_a,  4'd1);
    check("rst_alu_b",   bus.alu_b,  4'd3);
    check("rst_alu_op",  bus.alu_op, 2'd0);
    check("rst_miso",    bus.MISO,   1'b0);
    check("rst_busy",    busy,       1'b0);
    check("rst_res_q",   res_q,      4'd0);
    check("rst_flags_q", flags_q,    4'd0);
    check("rst_state",   o_state,    3'd0);

    // 1 + 3 = 4, no flags
    exp_q.push_back(8'b0100_0000);
    spi_frame(10'b00_0001_0011, -1, -1, dout_a);
    wait_clk(HALF);
    check_dout("f1_miso", dout_a);
    check("f1_load_pulses", n_load, 1);
    check("f1_alu_a",       bus.alu_a, 4'd1);
    check("f1_alu_b",       bus.alu_b, 4'd3);
    check("f1_res_q",       res_q, 4'd4);
    check("f1_flags_q",     flags_q, 4'd0);
    check("f1_done_pulses", n_done, 1);
    check("f1_err_pulses",  n_err, 0);

    // 7 + 1 = 8: signed overflow, negative
    exp_q.push_back(8'b1000_1001);
    spi_frame(10'b00_0111_0001, -1, -1, dout_a);
    wait_clk(HALF);
    check_dout("f2_miso", dout_a);
    check("f2_flags_q",     flags_q, 4'b1001);
    check("f2_res_q",       res_q, 4'd8);
    check("f2_alu_a",       bus.alu_a, 4'd7);
    check("f2_done_pulses", n_done, 2);

    // abort after 6 RX bits
    spi_frame(10'b01_1010_1100, 6, -1, dout_a);
    wait_clk(HALF);
    check("ab_err_pulses",  n_err, 1);
    check("ab_alu_a",       bus.alu_a, 4'd7);
    check("ab_alu_b",       bus.alu_b, 4'd1);
    check("ab_alu_op",      bus.alu_op, 2'd0);
    check("ab_res_q",       res_q, 4'd8);
    check("ab_flags_q",     flags_q, 4'b1001);
    check("ab_state",       o_state, 3'd0);
    check("ab_busy",        busy, 1'b0);
    check("ab_done_pulses", n_done, 2);
    check("ab_load_pulses", n_load, 2);

    // reset during TX bit 3
    spi_frame(10'b00_0010_0010, -1, 3, dout_a);
    check("tr_alu_a",       bus.alu_a, 4'd1);
    check("tr_alu_b",       bus.alu_b, 4'd3);
    check("tr_alu_op",      bus.alu_op, 2'd0);
    check("tr_res_q",       res_q, 4'd0);
    check("tr_flags_q",     flags_q, 4'd0);
    check("tr_miso",        bus.MISO, 1'b0);
    check("tr_busy",        busy, 1'b0);
    check("tr_state",       o_state, 3'd0);
    check("tr_err_pulses",  n_err, 1);
    check("tr_done_pulses", n_done, 2);

    // 6 + 3 = 9 after reset
    exp_q.push_back(8'b1001_1001);
    spi_frame(10'b00_0110_0011, -1, -1, dout_a);
    wait_clk(HALF);
    check_dout("f3_miso", dout_a);
    check("f3_res_q",       res_q, 4'd9);
    check("f3_done_pulses", n_done, 3);

    // back-to-back: F+1 = 0 with carry, then 5+6 = 11 with overflow
    exp_q.push_back(8'b0000_0110);
    exp_q.push_back(8'b1011_1001);
    spi_frame(10'b00_1111_0001, -1, -1, dout_a);
    wait_clk(4);
    spi_frame(10'b00_0101_0110, -1, -1, dout_b);
    wait_clk(HALF);
    check_dout("bb1_miso", dout_a);
    check_dout("bb2_miso", dout_b);
    check("bb_done_pulses", n_done, 5);
    check("bb_res_q",       res_q, 4'hB);
    check("bb_flags_q",     flags_q, 4'b1001);
    check("bb_err_pulses",  n_err, 1);
    check("bb_done_err_overlap", n_both, 0);
    check("bb_state",       o_state, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
